projectile_launcher: RTL and testbench



---
 rtl/game_pkg.sv | 33 +++
 rtl/projectile_launcher_if.sv | 27 ++
 rtl/projectile_tick_gen.sv | 29 ++
 rtl/projectile_launcher.sv | 143 ++++++++++++++
 tb/tb_projectile_launcher.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared game constants and types: coordinate width, screen limits, collision
// flag encoding, projectile directions and launcher FSM states.
package game_pkg;

  localparam int COORD_W = 9;

  localparam int SCREEN_X_MAX = 319;
  localparam int SCREEN_Y_MAX = 239;

  localparam logic [2:0] HIT_FLAG = 3'b100;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_UP    = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    FLY,
    SETTLE
  } launcher_state_t;

  // True when a requested launch point lies inside the visible screen.
  function automatic logic coord_legal(input logic [COORD_W-1:0] x,
                                       input logic [COORD_W-1:0] y,
                                       input int x_max,
                                       input int y_max);
    return (int'(x) <= x_max) && (int'(y) <= y_max);
  endfunction

endpackage

// File: rtl/projectile_launcher_if.sv
// Launch/collision bundle between the game controller, the projectile
// launcher and the collision checkers/renderer.
interface projectile_launcher_if;
  import game_pkg::*;

  logic               fire;
  logic [COORD_W-1:0] fire_x;
  logic [COORD_W-1:0] fire_y;
  logic [1:0]         fire_dir;
  logic [2:0]         flag;
  logic [COORD_W-1:0] x_cord;
  logic [COORD_W-1:0] y_cord;
  logic               active;
  logic               hit;
  logic               expired;

  modport master (
    input  fire, fire_x, fire_y, fire_dir, flag,
    output x_cord, y_cord, active, hit, expired
  );

  modport slave (
    output fire, fire_x, fire_y, fire_dir, flag,
    input  x_cord, y_cord, active, hit, expired
  );

endinterface

// File: rtl/projectile_tick_gen.sv
// Movement-rate divider: counts 0..SPEED_DIV-1 while enabled and flags the
// last count as the move tick. Clear holds the count at zero.
module projectile_tick_gen #(
  parameter int SPEED_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (SPEED_DIV > 2) ? $clog2(SPEED_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SPEED_DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/projectile_launcher.sv
// Launches a single projectile, steps it across the screen at the divided
// rate and reports collision hits or screen exits as one-cycle pulses.
module projectile_launcher
  import game_pkg::*;
#(
  parameter int SPEED_DIV = 4,
  parameter int STEP      = 2,
  parameter int X_MAX     = SCREEN_X_MAX,
  parameter int Y_MAX     = SCREEN_Y_MAX
) (
  input  logic                  clock,
  input  logic                  reset,
  projectile_launcher_if.master bus
);

  localparam int CALC_W = COORD_W + 1;
  localparam logic signed [CALC_W-1:0] STEP_S  = CALC_W'(STEP);
  localparam logic signed [CALC_W-1:0] X_MAX_S = CALC_W'(X_MAX);
  localparam logic signed [CALC_W-1:0] Y_MAX_S = CALC_W'(Y_MAX);

  launcher_state_t    state;
  dir_t               dir_q;
  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic               active_q;
  logic               hit_q;
  logic               expired_q;
  logic               stale;

  logic                     tick;
  logic                     launch_ok;
  logic                     flag_hit;
  logic                     leave;
  logic signed [CALC_W-1:0] sx;
  logic signed [CALC_W-1:0] sy;
  logic signed [CALC_W-1:0] nx;
  logic signed [CALC_W-1:0] ny;

  projectile_tick_gen #(
    .SPEED_DIV(SPEED_DIV)
  ) u_tick (
    .clock(clock),
    .reset(reset),
    .clear(state != FLY),
    .tick (tick)
  );

  assign launch_ok = bus.fire && coord_legal(bus.fire_x, bus.fire_y, X_MAX, Y_MAX);

  // The checker answers one cycle late, so its flag refers to a stale
  // position right after launch and right after every move.
  assign flag_hit = !stale && (bus.flag == HIT_FLAG);

  always_comb begin
    sx    = $signed({1'b0, x_q});
    sy    = $signed({1'b0, y_q});
    nx    = sx;
    ny    = sy;
    leave = 1'b0;
    case (dir_q)
      DIR_RIGHT: begin
        nx    = sx + STEP_S;
        leave = nx > X_MAX_S;
      end
      DIR_LEFT: begin
        leave = sx < STEP_S;
        nx    = sx - STEP_S;
      end
      DIR_DOWN: begin
        ny    = sy + STEP_S;
        leave = ny > Y_MAX_S;
      end
      default: begin
        leave = sy < STEP_S;
        ny    = sy - STEP_S;
      end
    endcase
  end

  // Hit outranks expiry, which outranks a move; the position never wraps.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      dir_q     <= DIR_RIGHT;
      x_q       <= '0;
      y_q       <= '0;
      active_q  <= 1'b0;
      hit_q     <= 1'b0;
      expired_q <= 1'b0;
      stale     <= 1'b0;
    end else begin
      hit_q     <= 1'b0;
      expired_q <= 1'b0;
      case (state)
        IDLE: begin
          if (launch_ok) begin
            x_q      <= bus.fire_x;
            y_q      <= bus.fire_y;
            dir_q    <= dir_t'(bus.fire_dir);
            active_q <= 1'b1;
            stale    <= 1'b1;
            state    <= FLY;
          end
        end
        FLY: begin
          stale <= 1'b0;
          if (flag_hit) begin
            hit_q    <= 1'b1;
            active_q <= 1'b0;
            state    <= SETTLE;
          end else if (tick && leave) begin
            expired_q <= 1'b1;
            active_q  <= 1'b0;
            state     <= SETTLE;
          end else if (tick) begin
            x_q   <= nx[COORD_W-1:0];
            y_q   <= ny[COORD_W-1:0];
            stale <= 1'b1;
          end
        end
        SETTLE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.x_cord  = x_q;
  assign bus.y_cord  = y_q;
  assign bus.active  = active_q;
  assign bus.hit     = hit_q;
  assign bus.expired = expired_q;

  a_pulse_exclusive : assert property (@(posedge clock) disable iff (reset)
    !(hit_q && expired_q));

  a_pulse_ends_flight : assert property (@(posedge clock) disable iff (reset)
    (hit_q || expired_q) |-> !active_q);

endmodule

// File: tb/tb_projectile_launcher.sv
// Scoreboard bench: each driven cycle queues the expected registered outputs,
// which a monitor pops and compares just after the following clock edge.
module tb_projectile_launcher;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  projectile_launcher_if bus ();

  projectile_launcher #(
    .SPEED_DIV(4),
    .STEP     (2),
    .X_MAX    (319),
    .Y_MAX    (239)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
    logic       active;
    logic       hit;
    logic       expired;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  exp_t  mon_e;
  string mon_t;

  int compared   = 0;
  int mismatched = 0;

  task automatic checkOutput(input string tag, input logic [8:0] actual,
                             input logic [8:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Drives one cycle of inputs (at a negedge) and queues what the outputs
  // must be after the next rising edge.
  task automatic applyStimulus(input string tag, input bit rst, input bit f,
                               input int fx, input int fy, input int dir,
                               input logic [2:0] flg, input int ex, input int ey,
                               input bit ea, input bit eh, input bit ee);
    exp_t e;
    reset        = rst;
    bus.fire     = f;
    bus.fire_x   = 9'(fx);
    bus.fire_y   = 9'(fy);
    bus.fire_dir = 2'(dir);
    bus.flag     = flg;
    e.x       = 9'(ex);
    e.y       = 9'(ey);
    e.active  = ea;
    e.hit     = eh;
    e.expired = ee;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clock);
  endtask

  task automatic flyCycles(input string tag, input int n, input logic [2:0] flg,
                           input int ex, input int ey);
    for (int i = 0; i < n; i++)
      applyStimulus(tag, 0, 0, 0, 0, 0, flg, ex, ey, 1, 0, 0);
  endtask

  task automatic launch(input string tag, input int fx, input int fy, input int dir);
    applyStimulus(tag, 0, 1, fx, fy, dir, 3'b000, fx, fy, 1, 0, 0);
  endtask

  always @(posedge clock) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      checkOutput({mon_t, ".x"},       bus.x_cord,        mon_e.x);
      checkOutput({mon_t, ".y"},       bus.y_cord,        mon_e.y);
      checkOutput({mon_t, ".active"},  9'(bus.active),    9'(mon_e.active));
      checkOutput({mon_t, ".hit"},     9'(bus.hit),       9'(mon_e.hit));
      checkOutput({mon_t, ".expired"}, 9'(bus.expired),   9'(mon_e.expired));
    end
  end

  initial begin
    bus.fire     = 1'b0;
    bus.fire_x   = '0;
    bus.fire_y   = '0;
    bus.fire_dir = '0;
    bus.flag     = '0;
    repeat (2) @(negedge clock);

    applyStimulus("reset", 1, 1, 100, 50, 0, 3'b100, 0, 0, 0, 0, 0);
    applyStimulus("reset_release", 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);

    // Rightward flight, stale flags, ignored re-fire, then a real hit.
    launch("r_launch", 100, 50, 0);
    applyStimulus("r_stale_launch", 0, 0, 0, 0, 0, 3'b100, 100, 50, 1, 0, 0);
    applyStimulus("r_nohit_flag", 0, 0, 0, 0, 0, 3'b010, 100, 50, 1, 0, 0);
    applyStimulus("r_refire", 0, 1, 10, 10, 1, 3'b000, 100, 50, 1, 0, 0);
    flyCycles("r_move1", 1, 3'b000, 102, 50);
    applyStimulus("r_stale_move", 0, 0, 0, 0, 0, 3'b100, 102, 50, 1, 0, 0);
    flyCycles("r_wait", 2, 3'b000, 102, 50);
    flyCycles("r_move2", 1, 3'b000, 104, 50);
    flyCycles("r_stale2", 1, 3'b000, 104, 50);
    applyStimulus("r_hit", 0, 0, 0, 0, 0, 3'b100, 104, 50, 0, 1, 0);
    applyStimulus("r_settle", 0, 0, 0, 0, 0, 3'b100, 104, 50, 0, 0, 0);
    applyStimulus("r_idle", 0, 0, 0, 0, 0, 3'b000, 104, 50, 0, 0, 0);

    applyStimulus("bad_x", 0, 1, 400, 20, 0, 3'b000, 104, 50, 0, 0, 0);
    applyStimulus("bad_y", 0, 1, 20, 240, 0, 3'b000, 104, 50, 0, 0, 0);

    // Right edge: 316 -> 318, then 320 would leave the screen.
    launch("e_launch", 316, 10, 0);
    flyCycles("e_fly", 3, 3'b000, 316, 10);
    flyCycles("e_move", 4, 3'b000, 318, 10);
    applyStimulus("e_expire", 0, 0, 0, 0, 0, 3'b000, 318, 10, 0, 0, 1);
    applyStimulus("e_settle", 0, 0, 0, 0, 0, 3'b000, 318, 10, 0, 0, 0);

    // Top edge: y=1 is below one step, so the first tick expires.
    launch("u_launch", 60, 1, 3);
    flyCycles("u_fly", 3, 3'b000, 60, 1);
    applyStimulus("u_expire", 0, 0, 0, 0, 0, 3'b000, 60, 1, 0, 0, 1);
    applyStimulus("u_settle", 0, 0, 0, 0, 0, 3'b000, 60, 1, 0, 0, 0);

    launch("rst_launch", 150, 100, 1);
    flyCycles("rst_fly", 1, 3'b000, 150, 100);
    applyStimulus("rst_mid", 1, 0, 0, 0, 0, 3'b100, 0, 0, 0, 0, 0);
    applyStimulus("rst_after", 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);

    // Hit and expiry on the same tick: the hit wins.
    launch("p_launch", 319, 200, 0);
    flyCycles("p_fly", 3, 3'b000, 319, 200);
    applyStimulus("p_hit", 0, 0, 0, 0, 0, 3'b100, 319, 200, 0, 1, 0);
    applyStimulus("p_settle", 0, 0, 0, 0, 0, 3'b000, 319, 200, 0, 0, 0);

    // Bottom edge: 237 -> 239 is legal, 241 is not.
    launch("d_launch", 5, 237, 2);
    flyCycles("d_fly", 3, 3'b000, 5, 237);
    flyCycles("d_move", 4, 3'b000, 5, 239);
    applyStimulus("d_expire", 0, 0, 0, 0, 0, 3'b000, 5, 239, 0, 0, 1);
    applyStimulus("d_settle", 0, 0, 0, 0, 0, 3'b000, 5, 239, 0, 0, 0);

    // Left edge: 2 -> 0 is legal, then the next tick expires.
    launch("l_launch", 2, 7, 1);
    flyCycles("l_fly", 3, 3'b000, 2, 7);
    flyCycles("l_move", 4, 3'b000, 0, 7);
    applyStimulus("l_expire", 0, 0, 0, 0, 0, 3'b000, 0, 7, 0, 0, 1);
    applyStimulus("l_settle", 0, 0, 0, 0, 0, 3'b000, 0, 7, 0, 0, 0);

    repeat (2) @(negedge clock);
    checkOutput("drain", 9'(exp_q.size()), 9'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
